// File: rtl/bsg_wormhole_router_pkg.sv
// Shared types and constants for the wormhole router output schedulers.
package bsg_wormhole_router_pkg;

  localparam int unsigned dirs_gp      = 5;
  localparam int unsigned len_width_gp = 4;

  typedef enum logic [0:0] {
    e_idle   = 1'b0,
    e_locked = 1'b1
  } sched_state_e;

endpackage

// File: rtl/bsg_wormhole_output_sched_if.sv
// Handshake bundle between one output scheduler, its input FIFOs and the crossbar.
interface bsg_wormhole_output_sched_if
  import bsg_wormhole_router_pkg::*;
#(
  parameter int unsigned inputs_p    = dirs_gp,
  parameter int unsigned len_width_p = len_width_gp
);

  logic [inputs_p-1:0]             reqs_i;
  logic [inputs_p*len_width_p-1:0] len_i;
  logic [inputs_p-1:0]             data_v_i;
  logic                            ready_i;
  logic                            valid_o;
  logic [inputs_p-1:0]             sel_o;
  logic [inputs_p-1:0]             yumi_o;
  logic                            busy_o;

  modport master (
    input  reqs_i, len_i, data_v_i, ready_i,
    output valid_o, sel_o, yumi_o, busy_o
  );

  modport slave (
    output reqs_i, len_i, data_v_i, ready_i,
    input  valid_o, sel_o, yumi_o, busy_o
  );

endinterface

// File: rtl/bsg_wormhole_rr_pick.sv
// Combinational round-robin picker: the first request strictly after the one-hot
// pointer wins, wrapping from the top bit back to bit 0.
module bsg_wormhole_rr_pick #(
  parameter int unsigned width_p = 5
) (
  input  logic [width_p-1:0] i_reqs,
  input  logic [width_p-1:0] i_ptr,
  output logic [width_p-1:0] o_grant_c
);

  int                 w_shift;
  logic [width_p-1:0] w_rot;
  logic [width_p-1:0] w_first;

  // Rotate so the slot after the pointer sits at bit 0, take the lowest set bit, rotate back.
  always_comb begin
    w_shift = 0;
    for (int i = 0; i < int'(width_p); i++) begin
      if (i_ptr[i]) w_shift = (i + 1) % int'(width_p);
    end
    w_rot     = width_p'({i_reqs, i_reqs} >> w_shift);
    w_first   = w_rot & (~w_rot + width_p'(1));
    o_grant_c = width_p'(({w_first, w_first} << w_shift) >> width_p);
  end

endmodule

// File: rtl/bsg_wormhole_output_sched.sv
// Per-output wormhole scheduler: round-robin head arbitration, then the output is
// locked to the winner until its header plus len body flits have gone out.
module bsg_wormhole_output_sched
  import bsg_wormhole_router_pkg::*;
#(
  parameter int unsigned inputs_p    = dirs_gp,
  parameter int unsigned len_width_p = len_width_gp
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  bsg_wormhole_output_sched_if.master io_if
);

  // Pointer parks on the top input so input 0 has first priority out of reset.
  localparam logic [inputs_p-1:0] ptr_rst_lp = inputs_p'(1) << (inputs_p - 1);

  sched_state_e           r_state;
  logic [inputs_p-1:0]    r_owner;
  logic [inputs_p-1:0]    r_ptr;
  logic [len_width_p-1:0] r_count;

  logic [inputs_p-1:0]    w_pick;
  logic [inputs_p-1:0]    w_sel;
  logic [len_width_p-1:0] w_head_len;
  logic                   w_valid;
  logic                   w_xfer;

  bsg_wormhole_rr_pick #(.width_p(inputs_p)) u_pick (
    .i_reqs    (io_if.reqs_i),
    .i_ptr     (r_ptr),
    .o_grant_c (w_pick)
  );

  always_comb begin
    w_head_len = '0;
    for (int i = 0; i < int'(inputs_p); i++) begin
      if (w_pick[i]) w_head_len = len_width_p'(io_if.len_i >> (i * len_width_p));
    end
  end

  always_comb begin
    w_sel   = '0;
    w_valid = 1'b0;
    case (r_state)
      e_idle: begin
        w_sel   = w_pick;
        w_valid = |io_if.reqs_i;
      end
      e_locked: begin
        w_sel   = r_owner;
        w_valid = |(io_if.data_v_i & r_owner);
      end
      default: ;
    endcase
  end

  // Reset masks every output in the cycle it is asserted, even mid-packet.
  assign w_xfer        = w_valid & io_if.ready_i & ~reset_i;
  assign io_if.valid_o = w_valid & ~reset_i;
  assign io_if.sel_o   = reset_i ? '0 : w_sel;
  assign io_if.yumi_o  = w_sel & {inputs_p{w_xfer}};
  assign io_if.busy_o  = (r_state == e_locked) & ~reset_i;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state <= e_idle;
      r_owner <= '0;
      r_count <= '0;
      r_ptr   <= ptr_rst_lp;
    end else if (w_xfer) begin
      case (r_state)
        e_idle: begin
          r_ptr <= w_sel;
          if (w_head_len != '0) begin
            r_state <= e_locked;
            r_owner <= w_sel;
            r_count <= w_head_len;
          end
        end
        e_locked: begin
          r_count <= r_count - len_width_p'(1);
          if (r_count == len_width_p'(1)) begin
            r_state <= e_idle;
            r_owner <= '0;
          end
        end
        default: r_state <= e_idle;
      endcase
    end
  end

endmodule

// File: tb/tb_bsg_wormhole_output_sched.sv
// Bench for the wormhole output scheduler: directed packets with literal checks plus
// randomized traffic, all compared every cycle against a packet-level reference model.
module tb_bsg_wormhole_output_sched;

  localparam int unsigned N  = 5;
  localparam int unsigned L  = 4;
  localparam int unsigned NL = N * L;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bsg_wormhole_output_sched_if #(.inputs_p(N), .len_width_p(L)) sif ();

  bsg_wormhole_output_sched #(.inputs_p(N), .len_width_p(L)) dut (
    .clk_i   (clk),
    .reset_i (rst),
    .io_if   (sif)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: last winner index, lock flag, owner index, flits still owed.
  int m_last, m_owner, m_rem;
  bit m_locked;
  logic [N-1:0] e_sel, e_yumi;
  logic         e_valid, e_busy;

  // Input-side traffic: phase 0 = nothing, 1 = head waiting, 2 = sending body.
  int d_phase[N];
  int d_rem[N];
  int d_len[N];
  int dv_pct;
  bit noise;
  logic [N-1:0] gap_mask;
  logic ready_v;

  logic [N-1:0] o_sel, o_yumi;
  logic         o_valid, o_busy;

  function automatic bit bit_at(logic [N-1:0] v, int i);
    return ((v >> i) & N'(1)) != '0;
  endfunction

  function automatic int pick(logic [N-1:0] r, int last);
    for (int k = 1; k <= int'(N); k++) begin
      int idx = (last + k) % int'(N);
      if (bit_at(r, idx)) return idx;
    end
    return -1;
  endfunction

  function automatic int len_field(logic [NL-1:0] lv, int w);
    logic [NL-1:0] t;
    t = lv >> (w * int'(L));
    return int'(t[L-1:0]);
  endfunction

  function automatic void model_eval();
    e_sel = '0; e_yumi = '0; e_valid = 1'b0; e_busy = 1'b0;
    if (!rst) begin
      if (!m_locked) begin
        int w = pick(sif.reqs_i, m_last);
        if (w >= 0) begin
          e_sel   = N'(1) << w;
          e_valid = 1'b1;
        end
      end else begin
        e_sel   = N'(1) << m_owner;
        e_valid = bit_at(sif.data_v_i, m_owner);
        e_busy  = 1'b1;
      end
      if (e_valid && sif.ready_i) e_yumi = e_sel;
    end
  endfunction

  function automatic void model_update();
    if (rst) begin
      m_locked = 1'b0; m_last = int'(N) - 1; m_rem = 0; m_owner = 0;
    end else if (e_valid && sif.ready_i) begin
      if (!m_locked) begin
        int w  = pick(sif.reqs_i, m_last);
        int ln = len_field(sif.len_i, w);
        m_last = w;
        if (ln > 0) begin
          m_locked = 1'b1; m_owner = w; m_rem = ln;
        end
      end else begin
        m_rem--;
        if (m_rem == 0) m_locked = 1'b0;
      end
    end
  endfunction

  function automatic void driver_update();
    for (int i = 0; i < int'(N); i++) begin
      if (rst) d_phase[i] = 0;
      else if (bit_at(e_yumi, i)) begin
        if (d_phase[i] == 1) begin
          if (d_len[i] == 0) d_phase[i] = 0;
          else begin d_phase[i] = 2; d_rem[i] = d_len[i]; end
        end else if (d_phase[i] == 2) begin
          d_rem[i]--;
          if (d_rem[i] == 0) d_phase[i] = 0;
        end
      end
    end
  endfunction

  task automatic drive();
    logic [N-1:0]  r, dv;
    logic [NL-1:0] lv;
    r = '0; dv = '0; lv = '0;
    for (int i = 0; i < int'(N); i++) begin
      int f;
      bit v;
      f = (d_phase[i] == 1) ? d_len[i] : (noise ? int'($urandom_range(0, 15)) : 0);
      lv = lv | (NL'(f) << (i * int'(L)));
      if (d_phase[i] == 1) r = r | (N'(1) << i);
      if (d_phase[i] == 2) v = int'($urandom_range(0, 99)) < dv_pct;
      else v = noise && ($urandom_range(0, 1) == 1);
      if (v) dv = dv | (N'(1) << i);
    end
    sif.reqs_i   = r;
    sif.data_v_i = dv & ~gap_mask;
    sif.len_i    = lv;
    sif.ready_i  = ready_v;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // One clock: drive at negedge, compare after settling, advance model after posedge.
  task automatic tick();
    drive();
    #1;
    model_eval();
    o_sel = sif.sel_o; o_valid = sif.valid_o; o_yumi = sif.yumi_o; o_busy = sif.busy_o;
    vectors++;
    if ({o_sel, o_valid, o_yumi, o_busy} !== {e_sel, e_valid, e_yumi, e_busy}) begin
      miscompares++;
      $display("FAIL cycle_outputs @%0t: got sel=%b valid=%b yumi=%b busy=%b, expected sel=%b valid=%b yumi=%b busy=%b",
               $time, o_sel, o_valid, o_yumi, o_busy, e_sel, e_valid, e_yumi, e_busy);
    end
    @(posedge clk);
    model_update();
    driver_update();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    for (int i = 0; i < int'(N); i++) begin d_phase[i] = 0; d_rem[i] = 0; d_len[i] = 0; end
  endtask

  initial begin
    int y, b, s, bad;
    int fair_exp[6];
    int b2b_exp[4];
    fair_exp = '{1, 2, 4, 8, 16, 1};
    b2b_exp  = '{2, 2, 2, 8};
    m_locked = 1'b0; m_last = int'(N) - 1; m_rem = 0; m_owner = 0;
    clear_inputs();
    dv_pct = 100; noise = 1'b0; gap_mask = '0; ready_v = 1'b1;
    rst = 1'b1;
    @(negedge clk);

    // Reset with requests present: everything masked.
    for (int i = 0; i < int'(N); i++) d_phase[i] = 1;
    tick();
    chk("reset_sel", int'(o_sel), 0);
    chk("reset_busy", int'(o_busy), 0);
    tick();
    rst = 1'b0;

    // Single request, len 3: four flits from input 2.
    d_phase[2] = 1; d_len[2] = 3;
    y = 0; b = 0; s = 0;
    for (int c = 0; c < 5; c++) begin
      tick();
      y += int'(o_yumi[2]); b += int'(o_busy); s += int'(o_sel == 5'b00100);
    end
    chk("single_yumis", y, 4);
    chk("single_busy_cycles", b, 3);
    chk("single_sel_cycles", s, 4);

    // Fairness after reset with all len-0 requests.
    rst = 1'b1; tick(); rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      for (int i = 0; i < int'(N); i++) begin d_phase[i] = 1; d_len[i] = 0; end
      tick();
      chk("fair_grant", int'(o_sel), fair_exp[c]);
    end

    // Back-to-back: input 1 (len 2) then input 3 head with no bubble.
    clear_inputs();
    d_phase[1] = 1; d_len[1] = 2; d_phase[3] = 1; d_len[3] = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("b2b_sel", int'(o_sel), b2b_exp[c]);
    end
    tick();

    // Backpressure 1010 plus a two-cycle valid gap on a len-4 packet.
    d_phase[4] = 1; d_len[4] = 4;
    y = 0; bad = 0;
    for (int c = 0; c < 20; c++) begin
      ready_v  = (c % 2 == 0);
      gap_mask = (c == 5 || c == 6) ? 5'b10000 : 5'b00000;
      tick();
      y += int'(o_yumi[4]);
      if (o_busy && o_sel != 5'b10000) bad++;
    end
    chk("bp_yumis", y, 5);
    chk("bp_sel_stable", bad, 0);
    chk("bp_released", int'(o_busy), 0);
    ready_v = 1'b1; gap_mask = '0;

    // Maximum length: 16 flits.
    d_phase[0] = 1; d_len[0] = 15;
    y = 0; b = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      y += int'(o_yumi[0]); b += int'(o_busy);
    end
    chk("maxlen_yumis", y, 16);
    chk("maxlen_busy_cycles", b, 15);

    // Reset in the middle of a len-5 packet.
    d_phase[2] = 1; d_len[2] = 5;
    tick(); tick();
    rst = 1'b1;
    tick();
    chk("midreset_yumi", int'(o_yumi), 0);
    rst = 1'b0;
    tick();
    chk("midreset_busy", int'(o_busy), 0);
    chk("midreset_sel", int'(o_sel), 0);
    for (int i = 0; i < int'(N); i++) begin d_phase[i] = 1; d_len[i] = 0; end
    tick();
    chk("midreset_first_grant", int'(o_sel), 1);
    clear_inputs();

    // Randomized traffic with noise on idle inputs and occasional resets.
    noise = 1'b1; dv_pct = 80;
    for (int c = 0; c < 3000; c++) begin
      rst     = ($urandom_range(0, 399) == 0);
      ready_v = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < int'(N); i++) begin
        if (d_phase[i] == 0 && $urandom_range(0, 5) == 0) begin
          d_phase[i] = 1;
          d_len[i]   = ($urandom_range(0, 7) == 0) ? 15 : int'($urandom_range(0, 3));
        end
      end
      tick();
    end
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bsg_wormhole_output_sched.md
Name: bsg_wormhole_output_sched

Overview:
- Per-output-port scheduler for a wormhole router.
- Arbitrates round-robin among input ports whose head flit targets this output.
- Locks the output to the winner for the whole packet (header plus len payload flits), then releases it.
- One instance per output direction; drives the output crossbar select and returns yumi to the input FIFOs.

Parameters:
- inputs_p, 5, number of requesting input ports (dirs_p of the router).
- len_width_p, 4, width of the header length field (payload flit count, header excluded).

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  synchronous, active-high reset.
- reqs_i  in  inputs_p  bit i = input i presents a head flit routed to this output.
- len_i  in  inputs_p*len_width_p  length field of input i's head flit; sampled only on head transfer.
- data_v_i  in  inputs_p  raw valid of each input FIFO (body flits).
- ready_i  in  1  downstream link ready.
- valid_o  out  1  flit valid toward downstream.
- sel_o  out  inputs_p  one-hot crossbar select; 0 when no grant.
- yumi_o  out  inputs_p  dequeue to input i, equal to sel_o[i] & valid_o & ready_i.
- busy_o  out  1  high while in LOCKED.

Behaviour:
- States: IDLE, LOCKED. Registers: state, owner (one-hot), remaining count (len_width_p bits), rr pointer (one-hot, last winner).
- Reset: state=IDLE, owner=0, count=0, pointer=one-hot bit inputs_p-1, so input 0 has highest priority.
- Reset outputs: sel_o=0, valid_o=0, yumi_o=0, busy_o=0.
- Reset mid-packet: lock is abandoned, state returns to IDLE; no yumi in the reset cycle.

IDLE:
- sel_o = round-robin pick over reqs_i, combinational, 0-cycle latency. Search starts at the bit after the pointer and wraps past inputs_p-1 to 0.
- valid_o = |reqs_i.
- On head transfer (valid_o & ready_i):
  - Pointer <= sel_o.
  - If len_i[winner] == 0: single-flit packet; stay IDLE, so a new grant is possible the next cycle.
  - Otherwise: count <= len_i[winner], owner <= sel_o, go to LOCKED.
- With no transfer, the pointer does not move. Requesters hold reqs_i until yumi, so the grant is stable.

LOCKED:
- sel_o = owner; valid_o = |(data_v_i & owner); reqs_i is ignored.
- Each transfer decrements count.
- A transfer with count==1 returns to IDLE in the next cycle. That cycle is a new arbitration, so there are no bubbles between back-to-back packets.
- An owner valid gap (data_v low) holds the lock; valid_o=0 and count is unchanged.
- ready_i low holds everything.

Boundary conditions:
- Maximum len (2^len_width_p-1) gives 2^len_width_p total flits; no overflow.
- A request from the same input as the last winner is served last among the current requesters (strict rotation).
- Simultaneous last-body transfer and new reqs_i: the new request is not seen until the IDLE cycle.

Decomposition:
- Shared package bsg_wormhole_router_pkg: state enum (IDLE/LOCKED), len field width constant.
- Sub-module bsg_wormhole_rr_pick (combinational): inputs reqs and one-hot pointer, output one-hot grant. Implemented by rotate, priority-encode, rotate back. Reused by other router ports.

Test Plan:
- Single request, no contention: reqs_i=5'b00100, len=3, ready=1 -> sel_o=00100 for 4 consecutive cycles, yumi_o[2] pulses 4 times, busy_o high 3 cycles, then IDLE.
- Fairness: reqs_i=5'b11111 constantly, all len=0, after reset -> grants in order 0,1,2,3,4,0 on consecutive cycles.
- Back-to-back lock: input 1 len=2 and input 3 len=0 both requesting -> flits from 1 on cycles 0-2, input 3 head on cycle 3, no bubble; input 3 is never granted during input 1's lock.
- Backpressure and gaps: owner len=4, ready_i toggles 1010…, data_v drops for 2 cycles mid-packet -> exactly 5 yumis, sel_o constant, count never under- or overflows.
- Max length: len=15 -> 16 flits transferred, then release.
- Reset mid-operation: reset_i at flit 2 of a len=5 packet -> next cycle sel_o=0, busy_o=0, pointer back to default, and input 0 wins the next arbitration.
